// File: rtl/tuple_stream_fifo_pkg.sv
// Shared sizing helpers for the tuple stream FIFO.
// Stored word layout is {flag, data}; the flag sits just above the data.
package tuple_stream_fifo_pkg;

    function automatic int packed_width(input int width);
        return width + 1;
    endfunction

    function automatic int flag_bit(input int width);
        return width;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tuple_stream_fifo_mem.sv
// Register array with one write port and one asynchronous read port.
// Contents are not reset; the owner gates reads while nothing is stored.
module tuple_fifo_mem #(
    parameter int WORD  = 6,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [WORD-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [WORD-1:0] rdata
);

    logic [WORD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tuple_stream_fifo.sv
// DEPTH-entry FIFO of (data, end-of-packet) tuples with valid/ready on both sides.
// Also reports occupancy and how many buffered entries close a packet.
module tuple_stream_fifo
    import tuple_stream_fifo_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESET,
    input  logic [WIDTH-1:0]              I__0,
    input  logic                          I__1,
    input  logic                          I_valid,
    output logic                          I_ready,
    output logic [WIDTH-1:0]              O__0,
    output logic                          O__1,
    output logic                          O_valid,
    input  logic                          O_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [$clog2(DEPTH+1)-1:0]    pkt_count
);

    localparam int PW       = packed_width(WIDTH);
    localparam int FLAG_BIT = flag_bit(WIDTH);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = cnt_width(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pkt_q;
    logic [PW-1:0] wr_word;
    logic [PW-1:0] rd_word;
    logic          push;
    logic          pop;
    logic          head_flag;

    function automatic logic [PW-1:0] pack_word(
        input logic             flag,
        input logic [WIDTH-1:0] data
    );
        return {flag, data};
    endfunction

    assign I_ready   = (count_q != CW'(DEPTH));
    assign O_valid   = (count_q != '0);
    assign push      = I_valid & I_ready;
    assign pop       = O_valid & O_ready;
    assign wr_word   = pack_word(I__1, I__0);
    assign head_flag = rd_word[FLAG_BIT];

    tuple_fifo_mem #(
        .WORD  (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            pkt_q   <= pkt_q + CW'(push & I__1) - CW'(pop & head_flag);
        end
    end

    // Stale memory is never visible while the FIFO is empty.
    assign O__0      = O_valid ? rd_word[WIDTH-1:0] : '0;
    assign O__1      = O_valid ? head_flag : 1'b0;
    assign count     = count_q;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_tuple_stream_fifo.sv
// Directed scoreboard bench for tuple_stream_fifo (WIDTH=5, DEPTH=4).
module tb_tuple_stream_fifo;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b0;
    logic [4:0] I__0 = '0;
    logic       I__1 = 1'b0;
    logic       I_valid = 1'b0;
    logic       I_ready;
    logic [4:0] O__0;
    logic       O__1;
    logic       O_valid;
    logic       O_ready = 1'b0;
    logic [2:0] count;
    logic [2:0] pkt_count;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] sb[$];

    tuple_stream_fifo #(.WIDTH(5), .DEPTH(4)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I__0       (I__0),
        .I__1       (I__1),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
        .O__0       (O__0),
        .O__1       (O__1),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .count      (count),
        .pkt_count  (pkt_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int flags_in_sb();
        int n = 0;
        foreach (sb[i]) n += int'(sb[i][5]);
        return n;
    endfunction

    task automatic chk_state(input string tag);
        logic [5:0] head;
        head = (sb.size() > 0) ? sb[0] : 6'h00;
        chk({tag, ".count"}, 32'(count), 32'(sb.size()));
        chk({tag, ".pkt"}, 32'(pkt_count), 32'(flags_in_sb()));
        chk({tag, ".i_ready"}, 32'(I_ready), 32'(sb.size() != 4));
        chk({tag, ".o_valid"}, 32'(O_valid), 32'(sb.size() != 0));
        chk({tag, ".o0"}, 32'(O__0), 32'(head[4:0]));
        chk({tag, ".o1"}, 32'(O__1), 32'(head[5]));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input string tag, input logic iv, input logic [4:0] d,
                        input logic f, input logic ordy);
        logic do_push;
        logic do_pop;
        I_valid = iv;
        I__0    = d;
        I__1    = f;
        O_ready = ordy;
        do_push = iv && (sb.size() < 4);
        do_pop  = ordy && (sb.size() > 0);
        @(posedge CLK);
        #1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back({f, d});
        chk_state(tag);
        @(negedge CLK);
        I_valid = 1'b0;
        O_ready = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        #2 ASYNCRESET = 1'b1;
        #1;
        sb.delete();
        chk_state(tag);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        #1;
        chk_state({tag, ".rel"});
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        pulse_reset("reset");

        step("single.push", 1'b1, 5'h15, 1'b1, 1'b0);
        step("single.pop", 1'b0, 5'h00, 1'b0, 1'b1);

        for (int i = 1; i <= 4; i++)
            step("fill", 1'b1, 5'(i), 1'(i % 2 == 0), 1'b0);
        step("full.drop", 1'b1, 5'h1f, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step("drain", 1'b0, 5'h00, 1'b0, 1'b1);

        step("sim.a", 1'b1, 5'd6, 1'b1, 1'b0);
        step("sim.b", 1'b1, 5'd8, 1'b0, 1'b0);
        step("sim.both", 1'b1, 5'd7, 1'b1, 1'b1);
        step("sim.d1", 1'b0, 5'h00, 1'b0, 1'b1);
        step("sim.d2", 1'b0, 5'h00, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++)
            step("wrap", 1'b1, 5'(i + 10), 1'(i % 3 == 0), i >= 2);
        while (sb.size() > 0)
            step("wrap.drain", 1'b0, 5'h00, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b1, 5'(i + 20), 1'b1, 1'b0);
        pulse_reset("mid_rst");
        step("post_rst.push", 1'b1, 5'd9, 1'b0, 1'b0);
        step("post_rst.pop", 1'b0, 5'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
